// File: rtl/percent_digit_splitter_pkg.sv
// Shared widths and the BCD digit triple used by the percentage display path.
package percent_digit_splitter_pkg;

    localparam int PCT_W = 8;
    localparam int BCD_W = 4;

    typedef struct packed {
        logic [BCD_W-1:0] hundreds;
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] units;
    } digits_t;

endpackage

// File: rtl/percent_digit_splitter_bin8_to_bcd3.sv
// Combinational double dabble: 8-bit binary to three BCD nibbles.
module percent_digit_splitter_bin8_to_bcd3
    import percent_digit_splitter_pkg::*;
(
    input  logic [PCT_W-1:0] bin_i,
    output digits_t          digits_o
);

    localparam int SCR_W = 3 * BCD_W + PCT_W;

    // Scratch is {bcd[11:0], bin[7:0]}; one add-3/shift round per input bit.
    logic [PCT_W:0][SCR_W-1:0]   stage;
    logic [PCT_W-1:0][SCR_W-1:0] adj;

    assign stage[0] = {{(3 * BCD_W){1'b0}}, bin_i};

    generate
        for (genvar gi = 0; gi < PCT_W; gi++) begin : g_round
            assign adj[gi][PCT_W-1:0] = stage[gi][PCT_W-1:0];
            for (genvar gj = 0; gj < 3; gj++) begin : g_nibble
                assign adj[gi][PCT_W + BCD_W*gj +: BCD_W] =
                    (stage[gi][PCT_W + BCD_W*gj +: BCD_W] >= 4'd5)
                        ? stage[gi][PCT_W + BCD_W*gj +: BCD_W] + 4'd3
                        : stage[gi][PCT_W + BCD_W*gj +: BCD_W];
            end
            assign stage[gi+1] = {adj[gi][SCR_W-2:0], 1'b0};
        end
    endgenerate

    assign digits_o.hundreds = stage[PCT_W][PCT_W + 2*BCD_W +: BCD_W];
    assign digits_o.tens     = stage[PCT_W][PCT_W + BCD_W   +: BCD_W];
    assign digits_o.units    = stage[PCT_W][PCT_W           +: BCD_W];

endmodule

// File: rtl/percent_digit_splitter.sv
// Clamps a binary percentage, splits it into BCD digits and registers the result.
module percent_digit_splitter
    import percent_digit_splitter_pkg::*;
#(
    parameter int MAX_PCT = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PCT_W-1:0] Percentage,
    input  logic             In_valid,
    output logic [BCD_W-1:0] Hundreds,
    output logic [BCD_W-1:0] Tens,
    output logic [BCD_W-1:0] Units,
    output logic             Out_valid,
    output logic             Overflow
);

    localparam logic [PCT_W-1:0] MAX_PCT_V = PCT_W'(MAX_PCT);

    logic [PCT_W-1:0] clamped;
    logic             over;
    digits_t          conv;

    digits_t digits_q, digits_d;
    logic    overflow_q, overflow_d;
    logic    valid_q, valid_d;

    assign over    = (Percentage > MAX_PCT_V);
    assign clamped = over ? MAX_PCT_V : Percentage;

    percent_digit_splitter_bin8_to_bcd3 u_bcd (
        .bin_i    (clamped),
        .digits_o (conv)
    );

    // Digits and flag hold while idle; only the valid strobe drops.
    always_comb begin
        digits_d   = digits_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;
        if (In_valid) begin
            digits_d   = conv;
            overflow_d = over;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digits_q   <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            digits_q   <= digits_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

    assign Hundreds  = digits_q.hundreds;
    assign Tens      = digits_q.tens;
    assign Units     = digits_q.units;
    assign Overflow  = overflow_q;
    assign Out_valid = valid_q;

endmodule

// File: tb/tb_percent_digit_splitter.sv
// Randomized and directed checks of percent_digit_splitter against an arithmetic model.
module tb_percent_digit_splitter;

    logic       clk;
    logic       rst_n;
    logic [7:0] Percentage;
    logic       In_valid;
    logic [3:0] Hundreds, Tens, Units;
    logic       Out_valid, Overflow;

    int total = 0;
    int bad   = 0;

    // Reference model state: what the outputs should show after the last edge.
    logic [3:0] m_h, m_t, m_u;
    logic       m_ov, m_valid;

    percent_digit_splitter #(.MAX_PCT(100)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Percentage (Percentage),
        .In_valid   (In_valid),
        .Hundreds   (Hundreds),
        .Tens       (Tens),
        .Units      (Units),
        .Out_valid  (Out_valid),
        .Overflow   (Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus, advance the model, settle 1 time unit past the edge.
    task automatic drive(input int p, input bit iv, input bit rn);
        int v;
        Percentage = 8'(p);
        In_valid   = iv;
        rst_n      = rn;
        @(posedge clk);
        #1;
        if (!rn) begin
            {m_h, m_t, m_u, m_ov, m_valid} = '0;
        end else if (iv) begin
            v       = (p > 100) ? 100 : p;
            m_h     = 4'(v / 100);
            m_t     = 4'((v / 10) % 10);
            m_u     = 4'(v % 10);
            m_ov    = (p > 100);
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(77, 1'b1, 1'b0);
            total++;
            if ({Hundreds, Tens, Units, Overflow, Out_valid} !== 14'd0) begin
                bad++;
                $display("FAIL reset[%0d]: got H=%0d T=%0d U=%0d ov=%b v=%b, want all 0",
                         i, Hundreds, Tens, Units, Overflow, Out_valid);
            end
        end
        drive(77, 1'b1, 1'b1);
        total++;
        if ({Hundreds, Tens, Units, Overflow, Out_valid} !== {4'd0, 4'd7, 4'd7, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_release: got H=%0d T=%0d U=%0d ov=%b v=%b, want 0/7/7 ov=0 v=1",
                     Hundreds, Tens, Units, Overflow, Out_valid);
        end
        $display("reset: %0d checks so far", total);
    endtask

    task automatic test_directed();
        int         vals [8] = '{49, 50, 0, 100, 75, 7, 101, 255};
        logic [12:0] exp [8] = '{{4'd0,4'd4,4'd9,1'b0}, {4'd0,4'd5,4'd0,1'b0},
                                 {4'd0,4'd0,4'd0,1'b0}, {4'd1,4'd0,4'd0,1'b0},
                                 {4'd0,4'd7,4'd5,1'b0}, {4'd0,4'd0,4'd7,1'b0},
                                 {4'd1,4'd0,4'd0,1'b1}, {4'd1,4'd0,4'd0,1'b1}};
        for (int i = 0; i < 8; i++) begin
            drive(vals[i], 1'b1, 1'b1);
            total++;
            if ({Hundreds, Tens, Units, Overflow, Out_valid} !== {exp[i], 1'b1}) begin
                bad++;
                $display("FAIL directed(%0d): got %0d/%0d/%0d ov=%b v=%b, want %0d/%0d/%0d ov=%b v=1",
                         vals[i], Hundreds, Tens, Units, Overflow, Out_valid,
                         exp[i][12:9], exp[i][8:5], exp[i][4:1], exp[i][0]);
            end
            $display("directed: in=%0d out=%0d/%0d/%0d ov=%b", vals[i], Hundreds, Tens, Units, Overflow);
        end
        drive(42, 1'b1, 1'b1);
        total++;
        if ({Hundreds, Tens, Units, Overflow, Out_valid} !== {4'd0, 4'd4, 4'd2, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL after_sat(42): got %0d/%0d/%0d ov=%b v=%b, want 0/4/2 ov=0 v=1",
                     Hundreds, Tens, Units, Overflow, Out_valid);
        end
    endtask

    task automatic test_hold();
        drive(63, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(12, 1'b0, 1'b1);
            total++;
            if ({Hundreds, Tens, Units, Overflow, Out_valid} !== {4'd0, 4'd6, 4'd3, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL hold[%0d]: got %0d/%0d/%0d ov=%b v=%b, want 0/6/3 ov=0 v=0",
                         i, Hundreds, Tens, Units, Overflow, Out_valid);
            end
        end
        $display("hold: held %0d/%0d/%0d", Hundreds, Tens, Units);
    endtask

    task automatic test_exhaustive();
        int errs = 0;
        for (int p = 0; p < 256; p++) begin
            drive(p, 1'b1, 1'b1);
            total++;
            if ({Hundreds, Tens, Units, Overflow, Out_valid} !== {m_h, m_t, m_u, m_ov, m_valid}
                || Tens > 4'd9 || Units > 4'd9) begin
                bad++;
                errs++;
                $display("FAIL sweep(%0d): got %0d/%0d/%0d ov=%b v=%b, want %0d/%0d/%0d ov=%b v=1",
                         p, Hundreds, Tens, Units, Overflow, Out_valid, m_h, m_t, m_u, m_ov);
            end
        end
        $display("exhaustive: 256 codes swept, %0d errors", errs);
    endtask

    task automatic test_midstream_reset();
        drive(88, 1'b1, 1'b1);
        drive(150, 1'b1, 1'b1);
        drive(91, 1'b1, 1'b0);
        total++;
        if ({Hundreds, Tens, Units, Overflow, Out_valid} !== 14'd0) begin
            bad++;
            $display("FAIL midreset: got %0d/%0d/%0d ov=%b v=%b, want all 0",
                     Hundreds, Tens, Units, Overflow, Out_valid);
        end
        drive(33, 1'b1, 1'b1);
        total++;
        if ({Hundreds, Tens, Units, Overflow, Out_valid} !== {4'd0, 4'd3, 4'd3, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL post_reset(33): got %0d/%0d/%0d ov=%b v=%b, want 0/3/3 ov=0 v=1",
                     Hundreds, Tens, Units, Overflow, Out_valid);
        end
        $display("midstream reset: resumed with %0d/%0d/%0d", Hundreds, Tens, Units);
    endtask

    task automatic test_random();
        int  p;
        bit  iv, rn;
        for (int i = 0; i < 300; i++) begin
            p  = $urandom_range(255);
            iv = ($urandom_range(3) != 0);
            rn = ($urandom_range(19) != 0);
            drive(p, iv, rn);
            total++;
            if ({Hundreds, Tens, Units, Overflow, Out_valid} !== {m_h, m_t, m_u, m_ov, m_valid}) begin
                bad++;
                $display("FAIL random[%0d] in=%0d iv=%b rn=%b: got %0d/%0d/%0d ov=%b v=%b, want %0d/%0d/%0d ov=%b v=%b",
                         i, p, iv, rn, Hundreds, Tens, Units, Overflow, Out_valid,
                         m_h, m_t, m_u, m_ov, m_valid);
            end
        end
        $display("random: 300 cycles checked");
    endtask

    initial begin
        rst_n      = 1'b0;
        In_valid   = 1'b0;
        Percentage = 8'd0;
        {m_h, m_t, m_u, m_ov, m_valid} = '0;
        test_reset();
        test_directed();
        test_hold();
        test_exhaustive();
        test_midstream_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
